// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, word type and arbiter FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} arb_state_t;

  // Watchdog counter width; kept at least 1 bit so tiny TIMEOUT values still elaborate.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter; slave = arbiter view, master = caches/RAM.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // Handshake: a cache holds its REN/WEN until it sees its wait low for one cycle;
  // load data is valid only in that wait-low cycle. Dropping the request aborts it.
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      err;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/arb_timeout.sv
// Saturating granted-cycle counter with a sticky error flag set when a grant expires.
module arb_timeout
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired,
  output logic err
);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (enable && expired) err <= 1'b1;
      if (clear) count <= '0;
      else if (enable && !expired) count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for icache/dcache with alternating priority, withdrawal and watchdog.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus,
  output arb_state_t    state
);
  arb_state_t next_state;
  logic last_d;
  logic req_i, req_d;
  logic done, abort, enable, clear, expired;

  assign req_i = bus.iREN;
  assign req_d = bus.dREN | bus.dWEN;

  arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (clear),
    .enable  (enable),
    .expired (expired),
    .err     (bus.err)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (done || abort) last_d <= (state == DGNT);
    end
  end

  always_comb begin
    next_state   = state;
    done         = 1'b0;
    abort        = 1'b0;
    enable       = 1'b0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      IDLE: begin
        if (req_i && req_d) next_state = last_d ? IGNT : DGNT;
        else if (req_i)     next_state = IGNT;
        else if (req_d)     next_state = DGNT;
      end
      IGNT: begin
        // RAM port follows the live request so a withdrawal drops it this cycle.
        bus.ramREN  = req_i;
        bus.ramaddr = req_i ? bus.iaddr : '0;
        bus.iload   = bus.ramload;
        if (!req_i) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait  = 1'b0;
          done       = 1'b1;
          next_state = IDLE;
        end else begin
          enable = 1'b1;
          if (expired) begin
            abort      = 1'b1;
            next_state = IDLE;
          end
        end
      end
      DGNT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = req_d ? bus.daddr : '0;
        bus.ramstore = req_d ? bus.dstore : '0;
        bus.dload    = bus.ramload;
        if (!req_d) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait  = 1'b0;
          done       = 1'b1;
          next_state = IDLE;
        end else begin
          enable = 1'b1;
          if (expired) begin
            abort      = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign clear = (state == IDLE) || (next_state == IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle stimulus with hand-computed expectations.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 4;

  logic       CLK = 1'b0;
  logic       nRST;
  arb_state_t state;
  int errors = 0;
  int checks = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .bus   (bus.slave),
    .state (state)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    #3;
    checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
    checks++; if ({bus.iwait, bus.dwait, bus.err} !== 3'b110) begin errors++; $display("FAIL reset_wait_err: got %b want 110", {bus.iwait, bus.dwait, bus.err}); end
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00 || bus.ramaddr !== 0 || bus.ramstore !== 0 || bus.iload !== 0 || bus.dload !== 0) begin
      errors++; $display("FAIL reset_outputs: ren=%b wen=%b addr=%h store=%h iload=%h dload=%h want all 0", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
    end
    do_reset();
  endtask

  task automatic test_i_read();
    tick(); bus.iREN = 1; bus.iaddr = 32'h40; #1;
    checks++; if (state !== IDLE || bus.ramREN !== 1'b0) begin errors++; $display("FAIL iread_c0: state=%0d ren=%b want IDLE,0", state, bus.ramREN); end
    tick(); bus.ramstate = BUSY; #1;
    checks++; if (state !== IGNT) begin errors++; $display("FAIL iread_grant: got %0d want %0d", state, IGNT); end
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b10 || bus.ramaddr !== 32'h40) begin errors++; $display("FAIL iread_ram: ren/wen=%b addr=%h want 10 00000040", {bus.ramREN, bus.ramWEN}, bus.ramaddr); end
    checks++; if ({bus.iwait, bus.dwait} !== 2'b11) begin errors++; $display("FAIL iread_c1_wait: got %b want 11", {bus.iwait, bus.dwait}); end
    tick(); bus.ramstate = BUSY; #1;
    checks++; if ({bus.iwait, bus.dwait} !== 2'b11) begin errors++; $display("FAIL iread_c2_wait: got %b want 11", {bus.iwait, bus.dwait}); end
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h8C010004; #1;
    checks++; if ({bus.iwait, bus.dwait} !== 2'b01) begin errors++; $display("FAIL iread_c3_wait: got %b want 01", {bus.iwait, bus.dwait}); end
    checks++; if (bus.iload !== 32'h8C010004 || bus.dload !== 0) begin errors++; $display("FAIL iread_load: iload=%h dload=%h want 8c010004 0", bus.iload, bus.dload); end
    tick(); bus.iREN = 0; bus.ramstate = FREE; bus.ramload = 0; #1;
    checks++; if (state !== IDLE || bus.iwait !== 1'b1) begin errors++; $display("FAIL iread_after: state=%0d iwait=%b want IDLE,1", state, bus.iwait); end
  endtask

  task automatic test_tie();
    do_reset();
    tick(); bus.iREN = 1; bus.iaddr = 32'h10; bus.dREN = 1; bus.daddr = 32'h20; #1;
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h1111; #1;
    checks++; if (state !== DGNT || bus.ramaddr !== 32'h20) begin errors++; $display("FAIL tie_first_d: state=%0d addr=%h want DGNT 00000020", state, bus.ramaddr); end
    checks++; if ({bus.iwait, bus.dwait} !== 2'b10 || bus.dload !== 32'h1111) begin errors++; $display("FAIL tie_d_done: wait=%b dload=%h want 10 00001111", {bus.iwait, bus.dwait}, bus.dload); end
    tick(); bus.ramstate = FREE; #1;
    checks++; if (state !== IDLE || {bus.iwait, bus.dwait} !== 2'b11) begin errors++; $display("FAIL tie_gap1: state=%0d wait=%b want IDLE 11", state, {bus.iwait, bus.dwait}); end
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h2222; #1;
    checks++; if (state !== IGNT || bus.ramaddr !== 32'h10) begin errors++; $display("FAIL tie_second_i: state=%0d addr=%h want IGNT 00000010", state, bus.ramaddr); end
    checks++; if ({bus.iwait, bus.dwait} !== 2'b01 || bus.iload !== 32'h2222) begin errors++; $display("FAIL tie_i_done: wait=%b iload=%h want 01 00002222", {bus.iwait, bus.dwait}, bus.iload); end
    tick(); bus.ramstate = FREE; #1;
    checks++; if (state !== IDLE || {bus.iwait, bus.dwait} !== 2'b11) begin errors++; $display("FAIL tie_gap2: state=%0d wait=%b want IDLE 11", state, {bus.iwait, bus.dwait}); end
    tick(); bus.ramstate = ACCESS; #1;
    checks++; if (state !== DGNT || {bus.iwait, bus.dwait} !== 2'b10) begin errors++; $display("FAIL tie_third_d: state=%0d wait=%b want DGNT 10", state, {bus.iwait, bus.dwait}); end
    tick(); idle_inputs(); #1;
  endtask

  task automatic test_write();
    tick(); bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; #1;
    for (int c = 1; c <= 3; c++) begin
      tick(); bus.ramstate = (c == 3) ? ACCESS : BUSY; #1;
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b01 || bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hDEADBEEF) begin
        errors++; $display("FAIL write_c%0d: ren/wen=%b addr=%h store=%h want 01 00000100 deadbeef", c, {bus.ramREN, bus.ramWEN}, bus.ramaddr, bus.ramstore);
      end
    end
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("FAIL write_done: dwait=%b want 0", bus.dwait); end
    tick(); idle_inputs(); #1;
  endtask

  task automatic test_withdraw();
    tick(); bus.dREN = 1; bus.daddr = 32'h300; #1;
    tick(); bus.ramstate = BUSY; bus.iREN = 1; bus.iaddr = 32'h200; #1;
    checks++; if (state !== DGNT || bus.ramREN !== 1'b1) begin errors++; $display("FAIL wd_grant: state=%0d ren=%b want DGNT 1", state, bus.ramREN); end
    tick(); bus.dREN = 0; #1;
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00 || {bus.iwait, bus.dwait} !== 2'b11) begin errors++; $display("FAIL wd_drop: strobes=%b wait=%b want 00 11", {bus.ramREN, bus.ramWEN}, {bus.iwait, bus.dwait}); end
    tick(); #1;
    checks++; if (state !== IDLE || bus.dwait !== 1'b1) begin errors++; $display("FAIL wd_idle: state=%0d dwait=%b want IDLE 1", state, bus.dwait); end
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h55; #1;
    checks++; if (state !== IGNT || bus.ramaddr !== 32'h200 || {bus.iwait, bus.dwait} !== 2'b01) begin
      errors++; $display("FAIL wd_next_i: state=%0d addr=%h wait=%b want IGNT 00000200 01", state, bus.ramaddr, {bus.iwait, bus.dwait});
    end
    tick(); idle_inputs(); #1;
  endtask

  task automatic test_timeout();
    tick(); bus.iREN = 1; bus.iaddr = 32'h44; #1;
    for (int c = 1; c <= 4; c++) begin
      tick(); bus.ramstate = BUSY; #1;
      checks++; if (state !== IGNT || bus.iwait !== 1'b1 || bus.err !== 1'b0) begin
        errors++; $display("FAIL to_granted_c%0d: state=%0d iwait=%b err=%b want IGNT 1 0", c, state, bus.iwait, bus.err);
      end
    end
    tick(); bus.iREN = 0; bus.ramstate = FREE; #1;
    checks++; if (state !== IDLE || bus.err !== 1'b1 || bus.iwait !== 1'b1) begin errors++; $display("FAIL to_abort: state=%0d err=%b iwait=%b want IDLE 1 1", state, bus.err, bus.iwait); end
    tick(); bus.dREN = 1; bus.daddr = 32'h8; #1;
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h77; #1;
    checks++; if (bus.dwait !== 1'b0 || bus.dload !== 32'h77) begin errors++; $display("FAIL to_recover: dwait=%b dload=%h want 0 00000077", bus.dwait, bus.dload); end
    tick(); idle_inputs(); #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_sticky: err=%b want 1", bus.err); end
  endtask

  task automatic test_reset_mid();
    tick(); bus.dREN = 1; bus.daddr = 32'hC0; #1;
    tick(); bus.ramstate = BUSY; #1;
    checks++; if (state !== DGNT || bus.ramREN !== 1'b1) begin errors++; $display("FAIL rm_grant: state=%0d ren=%b want DGNT 1", state, bus.ramREN); end
    nRST = 1'b0; #1;
    checks++; if (state !== IDLE || bus.ramREN !== 1'b0 || bus.ramaddr !== 0 || bus.dwait !== 1'b1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL rm_async: state=%0d ren=%b addr=%h dwait=%b err=%b want IDLE 0 0 1 0", state, bus.ramREN, bus.ramaddr, bus.dwait, bus.err);
    end
    idle_inputs(); #1; nRST = 1'b1;
    tick(); bus.dREN = 1; bus.daddr = 32'hC4; #1;
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h99; #1;
    checks++; if (state !== DGNT || bus.ramaddr !== 32'hC4 || bus.dwait !== 1'b0 || bus.dload !== 32'h99) begin
      errors++; $display("FAIL rm_next: state=%0d addr=%h dwait=%b dload=%h want DGNT 000000c4 0 00000099", state, bus.ramaddr, bus.dwait, bus.dload);
    end
    tick(); idle_inputs(); #1;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_tie();
    test_write();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
